// File: rtl/div_pkg.sv
// div_pkg
// Shared definitions for the restoring divider: default operand widths and
// the controller state encoding. Imported by restoring_div_8by4 and div_step.
package div_pkg;

  localparam int DVD_W_DEF = 8;  // dividend / quotient width
  localparam int DVS_W_DEF = 4;  // divisor / remainder width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// div_step
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor, keep the difference if it
// did not go negative.
//
// Ports:
//   r_in     [DVS_W-1:0]  partial remainder before the step
//   bit_in                next dividend bit (MSB first)
//   divisor  [DVS_W-1:0]  divisor
//   r_out    [DVS_W-1:0]  partial remainder after the step
//   q_bit                 quotient bit produced by the step
module div_step
  import div_pkg::*;
#(
  parameter int DVS_W = DVS_W_DEF
) (
  input  logic [DVS_W-1:0] r_in,
  input  logic             bit_in,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVS_W-1:0] r_out,
  output logic             q_bit
);

  logic [DVS_W:0] trial;
  logic [DVS_W:0] diff;

  assign trial = {r_in, bit_in};
  assign diff  = trial - {1'b0, divisor};

  always_comb begin
    r_out = trial[DVS_W-1:0];
    q_bit = 1'b0;
    if (trial >= {1'b0, divisor}) begin
      // Difference fits in DVS_W bits whenever the trial is accepted, since
      // the partial remainder entering a step is always below the divisor.
      // With divisor=0 this truncation yields dividend low bits as remainder.
      r_out = diff[DVS_W-1:0];
      q_bit = 1'b1;
    end
  end

endmodule

// File: rtl/restoring_div_8by4.sv
// restoring_div_8by4
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first.
// A single div_step instance is reused every BUSY cycle.
//
// Build option: define DIV_ZERO_DETECT_EN to short-circuit divide-by-zero
// (IDLE->DONE in one cycle with dbz=1). Without it dbz is tied to 0 and a zero
// divisor runs through the normal DVD_W-step path.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   start      request a division (accepted only while ready=1)
//   dividend   [DVD_W-1:0] sampled on the accepting edge
//   divisor    [DVS_W-1:0] sampled on the accepting edge
//   ready      high in IDLE
//   done       one-cycle pulse, results valid
//   quotient   [DVD_W-1:0] held until the next accepted start
//   remainder  [DVS_W-1:0] held until the next accepted start
//   dbz        divide-by-zero flag, valid with done
//
// state | meaning
// IDLE  | waiting for start, ready=1
// BUSY  | one restoring step per cycle, DVD_W cycles
// DONE  | done pulse, returns to IDLE next cycle
module restoring_div_8by4
  import div_pkg::*;
#(
  parameter int DVD_W = DVD_W_DEF,
  parameter int DVS_W = DVS_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             dbz
);

  localparam int CNT_W = (DVD_W > 1) ? $clog2(DVD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DVD_W - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [DVD_W-1:0] dvd_sh;   // remaining dividend bits shift out the top, quotient bits fill the bottom
  logic [DVS_W-1:0] dvs_q;
  logic [DVS_W-1:0] r_q;
  logic [DVS_W-1:0] r_nxt;
  logic             q_bit;
  logic             accept;
  logic             zero_div;

  assign accept = (state == IDLE) && start;

`ifdef DIV_ZERO_DETECT_EN
  assign zero_div = (divisor == '0);
`else
  assign zero_div = 1'b0;
`endif

  div_step #(.DVS_W(DVS_W)) u_step (
    .r_in    (r_q),
    .bit_in  (dvd_sh[DVD_W-1]),
    .divisor (dvs_q),
    .r_out   (r_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = zero_div ? DONE : BUSY;
      BUSY:    if (cnt == LAST_STEP) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ready = (state == IDLE);
  assign done  = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      dvd_sh    <= '0;
      dvs_q     <= '0;
      r_q       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (accept) begin
      cnt    <= '0;
      dvd_sh <= dividend;
      dvs_q  <= divisor;
      r_q    <= '0;
      if (zero_div) begin
        quotient  <= '1;
        remainder <= dividend[DVS_W-1:0];
      end
    end else if (state == BUSY) begin
      cnt    <= cnt + 1'b1;
      dvd_sh <= {dvd_sh[DVD_W-2:0], q_bit};
      r_q    <= r_nxt;
      if (cnt == LAST_STEP) begin
        quotient  <= {dvd_sh[DVD_W-2:0], q_bit};
        remainder <= r_nxt;
      end
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  logic dbz_q;
  always_ff @(posedge clk) begin
    if (!rst_n)      dbz_q <= 1'b0;
    else if (accept) dbz_q <= zero_div;
  end
  assign dbz = dbz_q;
`else
  assign dbz = 1'b0;
`endif

endmodule

// File: tb/tb_restoring_div_8by4.sv
module tb_restoring_div_8by4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       ready;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       dbz;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  restoring_div_8by4 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .ready     (ready),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drives one request (caller is #1 after an edge), waits for done.
  // lat = edges from the accepting edge to done, -1 on timeout.
  task automatic run_div(input logic [7:0] a, input logic [3:0] b, output int lat);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    dividend = 8'd0;
    divisor = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (dbz !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b exp=0", dbz); end
    total++; if (quotient !== 8'd0) begin bad++; $display("FAIL reset_quot got=%0d exp=0", quotient); end
    total++; if (remainder !== 4'd0) begin bad++; $display("FAIL reset_rem got=%0d exp=0", remainder); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int lat;
    run_div(8'd100, 4'd7, lat);
    total++; if (lat !== 8) begin bad++; $display("FAIL basic_latency got=%0d exp=8", lat); end
    total++; if (quotient !== 8'd14) begin bad++; $display("FAIL basic_quot got=%0d exp=14", quotient); end
    total++; if (remainder !== 4'd2) begin bad++; $display("FAIL basic_rem got=%0d exp=2", remainder); end
    total++; if (dbz !== 1'b0) begin bad++; $display("FAIL basic_dbz got=%b exp=0", dbz); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0 || ready !== 1'b1) begin bad++; $display("FAIL basic_after done=%b ready=%b exp done=0 ready=1", done, ready); end
    total++; if (quotient !== 8'd14) begin bad++; $display("FAIL basic_hold got=%0d exp=14", quotient); end
  endtask

  task automatic test_vectors();
    logic [7:0] va [5] = '{8'd255, 8'd5, 8'd255, 8'd200, 8'd0};
    logic [3:0] vb [5] = '{4'd15,  4'd9, 4'd1,   4'd13,  4'd3};
    logic [7:0] eq [5] = '{8'd17,  8'd0, 8'd255, 8'd15,  8'd0};
    logic [3:0] er [5] = '{4'd0,   4'd5, 4'd0,   4'd5,   4'd0};
    int lat;
    for (int k = 0; k < 5; k++) begin
      run_div(va[k], vb[k], lat);
      total++; if (lat !== 8) begin bad++; $display("FAIL vec%0d_latency got=%0d exp=8", k, lat); end
      total++; if (quotient !== eq[k]) begin bad++; $display("FAIL vec%0d_quot got=%0d exp=%0d", k, quotient, eq[k]); end
      total++; if (remainder !== er[k]) begin bad++; $display("FAIL vec%0d_rem got=%0d exp=%0d", k, remainder, er[k]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_zero();
    int lat;
    int exp_lat;
    logic exp_dbz;
`ifdef DIV_ZERO_DETECT_EN
    exp_lat = 1;
    exp_dbz = 1'b1;
`else
    exp_lat = 8;
    exp_dbz = 1'b0;
`endif
    run_div(8'hA7, 4'd0, lat);
    total++; if (lat !== exp_lat) begin bad++; $display("FAIL dz_latency got=%0d exp=%0d", lat, exp_lat); end
    total++; if (quotient !== 8'hFF) begin bad++; $display("FAIL dz_quot got=%h exp=ff", quotient); end
    total++; if (remainder !== 4'd7) begin bad++; $display("FAIL dz_rem got=%0d exp=7", remainder); end
    total++; if (dbz !== exp_dbz) begin bad++; $display("FAIL dz_dbz got=%b exp=%b", dbz, exp_dbz); end
    @(posedge clk); #1;
  endtask

  task automatic test_start_during_busy();
    int pulses = 0;
    int lat = -1;
    dividend = 8'd100;
    divisor  = 4'd7;
    start    = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 30; i++) begin
      #1;
      dividend = 8'($urandom_range(0, 255));
      divisor  = 4'($urandom_range(1, 15));
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL busy_ready cyc=%0d got=%b exp=0", i, ready); end
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        pulses++;
        start = 1'b0;
        break;
      end
    end
    total++; if (lat !== 8) begin bad++; $display("FAIL busy_latency got=%0d exp=8", lat); end
    total++; if (quotient !== 8'd14) begin bad++; $display("FAIL busy_quot got=%0d exp=14", quotient); end
    total++; if (remainder !== 4'd2) begin bad++; $display("FAIL busy_rem got=%0d exp=2", remainder); end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL busy_pulses got=%0d exp=1", pulses); end
    total++; if (quotient !== 8'd14) begin bad++; $display("FAIL busy_hold got=%0d exp=14", quotient); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    int lat;
    dividend = 8'd100;
    divisor  = 4'd7;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n    = 1'b0;
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 4'd3;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b0;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", ready); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rmid_done got=%b exp=0", done); end
    total++; if (quotient !== 8'd0) begin bad++; $display("FAIL rmid_quot got=%0d exp=0", quotient); end
    total++; if (remainder !== 4'd0) begin bad++; $display("FAIL rmid_rem got=%0d exp=0", remainder); end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL rmid_no_done got=%0d exp=0", pulses); end
    run_div(8'd9, 4'd3, lat);
    total++; if (lat !== 8) begin bad++; $display("FAIL rmid_latency got=%0d exp=8", lat); end
    total++; if (quotient !== 8'd3) begin bad++; $display("FAIL rmid_quot2 got=%0d exp=3", quotient); end
    total++; if (remainder !== 4'd0) begin bad++; $display("FAIL rmid_rem2 got=%0d exp=0", remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int c1 = -1;
    int c2 = -1;
    dividend = 8'd100;
    divisor  = 4'd7;
    start    = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done) begin
        c1 = cyc;
        break;
      end
    end
    total++; if (c1 < 0) begin bad++; $display("FAIL b2b_first_timeout got=none exp=done"); end
    total++; if (quotient !== 8'd14 || remainder !== 4'd2) begin bad++; $display("FAIL b2b_first got=%0d r%0d exp=14 r2", quotient, remainder); end
    dividend = 8'd50;
    divisor  = 4'd6;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done) begin
        c2 = cyc;
        break;
      end
    end
    total++; if (quotient !== 8'd8 || remainder !== 4'd2) begin bad++; $display("FAIL b2b_second got=%0d r%0d exp=8 r2", quotient, remainder); end
    total++; if (c2 - c1 !== 10) begin bad++; $display("FAIL b2b_spacing got=%0d exp=10", c2 - c1); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_start_during_busy();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/restoring_div_8by4.md
RESTORING_DIV_8BY4 -- requirements
Module: restoring_div_8by4

Interface
REQ-001 SHALL have parameter DVD_W, default 8, meaning dividend and quotient width.
REQ-002 SHALL have parameter DVS_W, default 4, meaning divisor and remainder width.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-005 SHALL have port start  input  1  request a division; accepted only while ready=1.
REQ-006 SHALL have port dividend  input  DVD_W  unsigned dividend, sampled on the accepting edge.
REQ-007 SHALL have port divisor  input  DVS_W  unsigned divisor, sampled on the accepting edge.
REQ-008 SHALL have port ready  output  1  high only in IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse; quotient and remainder are valid.
REQ-010 SHALL have port quotient  output  DVD_W  unsigned quotient.
REQ-011 SHALL have port remainder  output  DVS_W  unsigned remainder.
REQ-012 SHALL have port dbz  output  1  divide-by-zero flag, valid with done.

Function
REQ-013 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-014 SHALL transition IDLE->BUSY on the edge where start=1, latching the operands and clearing the partial remainder R (DVS_W bits) and the step counter.
REQ-015 SHALL perform one restoring step per BUSY cycle, MSB first: T={R,next dividend bit} (DVS_W+1 bits); if T>={0,divisor}, R=T-divisor truncated to DVS_W bits and the quotient bit is 1; otherwise R=T[DVS_W-1:0] and the quotient bit is 0.
REQ-016 SHALL make exactly DVD_W BUSY steps; BUSY->DONE on the edge of the last step, so done is high starting DVD_W cycles after the accepting edge (8 by default).
REQ-017 SHALL hold done high for exactly one cycle, transition DONE->IDLE unconditionally, and keep quotient and remainder stable until the next accepted start.
REQ-018 SHALL ignore start while in BUSY or DONE (ready=0); in-flight operands SHALL be unaffected.
REQ-019 SHALL accept start in IDLE on the cycle immediately after DONE, which gives back-to-back throughput of one result per DVD_W+2 cycles.
REQ-020 SHALL produce quotient=all-ones and remainder=dividend[DVS_W-1:0] for divisor=0 (this is the natural datapath result, required either way).
REQ-021 SHALL keep operand changes after the accepting edge from affecting the result.

Reset
REQ-022 SHALL, on rst_n=0 at a clock edge, force state=IDLE, ready=1, done=0, dbz=0, quotient=0, remainder=0 and counter=0.
REQ-023 SHALL abandon an in-flight operation on reset mid-operation; no done pulse SHALL follow it.
REQ-024 SHALL ignore start on any edge where rst_n=0.

Configuration
REQ-025 SHALL recognise the macro DIV_ZERO_DETECT_EN.
REQ-026 SHALL, with DIV_ZERO_DETECT_EN defined, go IDLE->DONE directly on an accepted start with divisor=0, with done on the next cycle, dbz=1, and quotient and remainder per REQ-020.
REQ-027 SHALL, without DIV_ZERO_DETECT_EN, tie dbz to 0 and process divisor=0 through the normal DVD_W-step path.

Structure
REQ-028 SHALL place the FSM state enum (IDLE/BUSY/DONE) and the default width constants in the shared package div_pkg.
REQ-029 SHALL put the single combinational restoring step (compare/subtract/select, REQ-015) in the sub-module div_step, instantiated once and reused each cycle.

Verification
REQ-030 SHALL cover: dividend=100, divisor=7 -> after 8 cycles done=1, quotient=14, remainder=2, dbz=0.
REQ-031 SHALL cover: 255/15 -> quotient=17, remainder=0; 5/9 -> quotient=0, remainder=5; 255/1 -> quotient=255, remainder=0.
REQ-032 SHALL cover: 0xA7/0 -> quotient=0xFF, remainder=7; with the macro, done after 1 cycle and dbz=1; without it, done after 8 cycles and dbz=0.
REQ-033 SHALL cover: start=1 with new operands every cycle during BUSY -> the first result is unchanged, and exactly one done pulse occurs per accepted start.
REQ-034 SHALL cover: rst_n=0 at step 4 of 100/7 -> next cycle ready=1, done=0, quotient=0, remainder=0; a following 9/3 -> quotient=3, remainder=0.
REQ-035 SHALL cover: back-to-back 100/7 then 50/6, with start held high -> results 14 r2 then 8 r2, with done pulses 10 cycles apart.
